// File: rtl/cache_victim_ctrl.sv
// cache_victim_ctrl: miss/replacement controller for one set-associative cache bank.
// Accepts a miss, picks a victim way (first invalid way, else the one-hot LRU way, else
// way 0), writes a dirty victim back, requests the fill, then commits the new line and
// pulses lru_touch so the LRU FSM marks the filled way as most recently used.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   miss_v/miss_rdy          miss request handshake; miss_tag/miss_idx latched on accept
//   way_valid/way_dirty      per-way state of the addressed set, sampled in SELECT
//   way_tags, lru_way        per-way tags and one-hot LRU way, sampled in SELECT
//   wb_v/wb_rdy              writeback handshake; wb_addr = {victim_tag, idx}, wb_way
//   fill_v/fill_rdy          fill request handshake; fill_addr = {miss_tag, idx}
//   fill_data_v              single-beat fill data return
//   way_we, lru_touch        one-cycle one-hot strobes in COMMIT
//   miss_done                one-cycle pulse when the miss is serviced
//
// Optional: define VICTIM_CTRL_PERF_EN to add perf_miss_cnt / perf_wb_cnt (16-bit,
// wrapping) counting serviced misses and writeback handshakes.
module cache_victim_ctrl #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_v,
  output logic                   miss_rdy,
  input  logic [TAG_W-1:0]       miss_tag,
  input  logic [IDX_W-1:0]       miss_idx,
  input  logic [WAYS-1:0]        way_valid,
  input  logic [WAYS-1:0]        way_dirty,
  input  logic [WAYS*TAG_W-1:0]  way_tags,
  input  logic [WAYS-1:0]        lru_way,
  output logic                   wb_v,
  input  logic                   wb_rdy,
  output logic [TAG_W+IDX_W-1:0] wb_addr,
  output logic [WAYS-1:0]        wb_way,
  output logic                   fill_v,
  input  logic                   fill_rdy,
  output logic [TAG_W+IDX_W-1:0] fill_addr,
  input  logic                   fill_data_v,
  output logic [WAYS-1:0]        way_we,
  output logic [WAYS-1:0]        lru_touch,
  output logic                   miss_done
`ifdef VICTIM_CTRL_PERF_EN
  ,
  output logic [15:0]            perf_miss_cnt,
  output logic [15:0]            perf_wb_cnt
`endif
);

  localparam int unsigned WIW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StWbReq,
    StFillReq,
    StFillWait,
    StCommit
  } state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0] tag_q, vtag_q;
  logic [IDX_W-1:0] idx_q;
  logic [WAYS-1:0]  victim_q;
  logic             vdirty_q;

  // Victim selection, only consumed in StSelect.
  logic [WIW-1:0]   sel_idx;
  logic [WAYS-1:0]  sel_way;
  logic [TAG_W-1:0] sel_tag;
  logic             sel_dirty;
  logic             found_inv;
  logic             lru_onehot;

  always_comb begin
    sel_idx    = '0;
    found_inv  = 1'b0;
    lru_onehot = (lru_way != '0) && ((lru_way & (lru_way - WAYS'(1))) == '0);
    for (int i = 0; i < WAYS; i++) begin
      if (!way_valid[i] && !found_inv) begin
        found_inv = 1'b1;
        sel_idx   = WIW'(i);
      end
    end
    if (!found_inv && lru_onehot) begin
      for (int i = 0; i < WAYS; i++) begin
        if (lru_way[i]) sel_idx = WIW'(i);
      end
    end
    sel_way   = WAYS'(1) << sel_idx;
    sel_tag   = way_tags[sel_idx*TAG_W +: TAG_W];
    sel_dirty = way_valid[sel_idx] & way_dirty[sel_idx];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (miss_v) state_d = StSelect;
      StSelect:   state_d = sel_dirty ? StWbReq : StFillReq;
      StWbReq:    if (wb_rdy) state_d = StFillReq;
      StFillReq:  if (fill_rdy) state_d = StFillWait;
      StFillWait: if (fill_data_v) state_d = StCommit;
      StCommit:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tag_q    <= '0;
      idx_q    <= '0;
      victim_q <= '0;
      vtag_q   <= '0;
      vdirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && miss_v) begin
        tag_q <= miss_tag;
        idx_q <= miss_idx;
      end
      if (state_q == StSelect) begin
        victim_q <= sel_way;
        vtag_q   <= sel_tag;
        vdirty_q <= sel_dirty;
      end
    end
  end

  always_comb begin
    miss_rdy  = (state_q == StIdle);
    wb_v      = (state_q == StWbReq);
    wb_addr   = {vtag_q, idx_q};
    wb_way    = victim_q;
    fill_v    = (state_q == StFillReq);
    fill_addr = {tag_q, idx_q};
    miss_done = (state_q == StCommit);
    way_we    = miss_done ? victim_q : '0;
    lru_touch = miss_done ? victim_q : '0;
  end

`ifdef VICTIM_CTRL_PERF_EN
  logic [15:0] perf_miss_q, perf_wb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_miss_q <= '0;
      perf_wb_q   <= '0;
    end else begin
      if (miss_done)     perf_miss_q <= perf_miss_q + 16'd1;
      if (wb_v && wb_rdy) perf_wb_q  <= perf_wb_q + 16'd1;
    end
  end

  assign perf_miss_cnt = perf_miss_q;
  assign perf_wb_cnt   = perf_wb_q;
`endif

endmodule

// File: tb/tb_cache_victim_ctrl.sv
module tb_cache_victim_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_v;
  logic        miss_rdy;
  logic [7:0]  miss_tag;
  logic [3:0]  miss_idx;
  logic [3:0]  way_valid, way_dirty, lru_way;
  logic [31:0] way_tags;
  logic        wb_v, wb_rdy;
  logic [11:0] wb_addr;
  logic [3:0]  wb_way;
  logic        fill_v, fill_rdy;
  logic [11:0] fill_addr;
  logic        fill_data_v;
  logic [3:0]  way_we, lru_touch;
  logic        miss_done;
`ifdef VICTIM_CTRL_PERF_EN
  logic [15:0] perf_miss_cnt, perf_wb_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_victim_ctrl #(.WAYS(4), .TAG_W(8), .IDX_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .miss_v      (miss_v),
    .miss_rdy    (miss_rdy),
    .miss_tag    (miss_tag),
    .miss_idx    (miss_idx),
    .way_valid   (way_valid),
    .way_dirty   (way_dirty),
    .way_tags    (way_tags),
    .lru_way     (lru_way),
    .wb_v        (wb_v),
    .wb_rdy      (wb_rdy),
    .wb_addr     (wb_addr),
    .wb_way      (wb_way),
    .fill_v      (fill_v),
    .fill_rdy    (fill_rdy),
    .fill_addr   (fill_addr),
    .fill_data_v (fill_data_v),
    .way_we      (way_we),
    .lru_touch   (lru_touch),
    .miss_done   (miss_done)
`ifdef VICTIM_CTRL_PERF_EN
    ,
    .perf_miss_cnt (perf_miss_cnt),
    .perf_wb_cnt   (perf_wb_cnt)
`endif
  );

  // Way tags shared by all vectors: way3=7A, way2=C3, way1=B4, way0=19.
  localparam logic [31:0] Tags = 32'h7AC3B419;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  dirty;
    logic [3:0]  lru;
    logic [7:0]  tag;
    logic [3:0]  idx;
    logic [3:0]  exp_way;
    logic        exp_wb;
    logic [11:0] exp_wb_addr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_set(input vec_t v);
    way_valid = v.valid;
    way_dirty = v.dirty;
    lru_way   = v.lru;
    way_tags  = Tags;
    miss_tag  = v.tag;
    miss_idx  = v.idx;
  endtask

  // One miss with memory always ready; records what the DUT showed along the way.
  task automatic do_miss(input vec_t v, output logic [3:0] we, output logic [3:0] touch,
                         output logic wb_seen, output logic [11:0] wba,
                         output logic [3:0] wbw, output logic [11:0] fa,
                         output int lat, output int stray);
    we = '0; touch = '0; wb_seen = 1'b0; wba = '0; wbw = '0; fa = '0; lat = 0; stray = 0;
    @(negedge clk);
    drive_set(v);
    wb_rdy = 1'b1; fill_rdy = 1'b1; fill_data_v = 1'b1;
    chk("miss_rdy_before", 32'(miss_rdy), 32'd1);
    miss_v = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      miss_v = 1'b0;
      if (wb_v) begin wb_seen = 1'b1; wba = wb_addr; wbw = wb_way; end
      if (fill_v) fa = fill_addr;
      if (miss_done) begin
        we = way_we; touch = lru_touch; lat = n;
        break;
      end
      if (way_we != 4'b0 || lru_touch != 4'b0) stray++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0]  g_we, g_touch, g_wbw;
  logic        g_wb;
  logic [11:0] g_wba, g_fa;
  int          g_lat, g_stray;
  bit          seen;

  initial begin
    rst = 1'b1; miss_v = 1'b0; miss_tag = '0; miss_idx = '0;
    way_valid = '0; way_dirty = '0; lru_way = '0; way_tags = '0;
    wb_rdy = 1'b0; fill_rdy = 1'b0; fill_data_v = 1'b0;

    //           valid    dirty    lru      tag    idx   way      wb    wb_addr  lat
    vecs[0] = '{4'b1011, 4'b0000, 4'b0001, 8'h3C, 4'h5, 4'b0100, 1'b0, 12'h000, 4};
    vecs[1] = '{4'b1111, 4'b1000, 4'b1000, 8'h11, 4'h2, 4'b1000, 1'b1, 12'h7A2, 5};
    vecs[2] = '{4'b1111, 4'b0000, 4'b0110, 8'h22, 4'h3, 4'b0001, 1'b0, 12'h000, 4};
    vecs[3] = '{4'b1111, 4'b0000, 4'b0000, 8'h33, 4'h4, 4'b0001, 1'b0, 12'h000, 4};
    vecs[4] = '{4'b0000, 4'b1111, 4'b0100, 8'h44, 4'h6, 4'b0001, 1'b0, 12'h000, 4};
    vecs[5] = '{4'b1111, 4'b0010, 4'b0010, 8'hE0, 4'hF, 4'b0010, 1'b1, 12'hB4F, 5};
    vecs[6] = '{4'b0111, 4'b1111, 4'b0001, 8'h55, 4'h7, 4'b1000, 1'b0, 12'h000, 4};
    vecs[7] = '{4'b1111, 4'b0100, 4'b0001, 8'h66, 4'h8, 4'b0001, 1'b0, 12'h000, 4};

    // T1: reset held with a miss offered must not start anything.
    miss_v = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_miss_rdy", 32'(miss_rdy), 32'd1);
      chk("rst_pulses", {26'd0, wb_v, fill_v, miss_done, (way_we != 0), (lru_touch != 0),
                         (wb_way != 0)}, 32'd0);
    end
    miss_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(miss_rdy), 32'd1);

    // Table-driven victim selection with immediate memory response.
    for (int i = 0; i < 8; i++) begin
      do_miss(vecs[i], g_we, g_touch, g_wb, g_wba, g_wbw, g_fa, g_lat, g_stray);
      chk($sformatf("v%0d_way_we", i), 32'(g_we), 32'(vecs[i].exp_way));
      chk($sformatf("v%0d_lru_touch", i), 32'(g_touch), 32'(vecs[i].exp_way));
      chk($sformatf("v%0d_wb_seen", i), 32'(g_wb), 32'(vecs[i].exp_wb));
      if (vecs[i].exp_wb) begin
        chk($sformatf("v%0d_wb_addr", i), 32'(g_wba), 32'(vecs[i].exp_wb_addr));
        chk($sformatf("v%0d_wb_way", i), 32'(g_wbw), 32'(vecs[i].exp_way));
      end
      chk($sformatf("v%0d_fill_addr", i), 32'(g_fa), 32'({vecs[i].tag, vecs[i].idx}));
      chk($sformatf("v%0d_latency", i), 32'(g_lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_stray", i), 32'(g_stray), 32'd0);
    end

    // T3: writeback stalled by wb_rdy=0; set contents change after SELECT (ignored).
    @(negedge clk);
    drive_set(vecs[1]);
    wb_rdy = 1'b0; fill_rdy = 1'b1; fill_data_v = 1'b1; miss_v = 1'b1;
    @(negedge clk);
    miss_v = 1'b0;
    chk("t3_select", 32'(miss_rdy), 32'd0);
    @(negedge clk);
    way_valid = 4'b0000; way_dirty = 4'b0000; lru_way = 4'b0001; way_tags = '0;
    for (int k = 0; k < 4; k++) begin
      chk("t3_wb_v_hold", 32'(wb_v), 32'd1);
      chk("t3_wb_addr_hold", 32'(wb_addr), 32'h7A2);
      chk("t3_wb_way_hold", 32'(wb_way), 32'b1000);
      chk("t3_no_fill_yet", 32'(fill_v), 32'd0);
      if (k == 3) wb_rdy = 1'b1;
      @(negedge clk);
    end
    chk("t3_fill_v", 32'(fill_v), 32'd1);
    chk("t3_fill_addr", 32'(fill_addr), 32'h112);
    chk("t3_wb_v_drop", 32'(wb_v), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t3_done", 32'(miss_done), 32'd1);
    chk("t3_way_we", 32'(way_we), 32'b1000);

    // T5: reset while waiting for fill data; late data must not commit.
    @(negedge clk);
    drive_set(vecs[0]);
    wb_rdy = 1'b1; fill_rdy = 1'b1; fill_data_v = 1'b0; miss_v = 1'b1;
    @(negedge clk);
    miss_v = 1'b0;
    @(negedge clk);
    chk("t5_fill_req", 32'(fill_v), 32'd1);
    @(negedge clk);
    chk("t5_fill_wait", {30'd0, fill_v, miss_rdy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fill_data_v = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (miss_done || way_we != 0 || lru_touch != 0) seen = 1'b1;
    end
    chk("t5_no_commit", 32'(seen), 32'd0);
    chk("t5_idle", 32'(miss_rdy), 32'd1);

    // T6: back-to-back misses with miss_v held high, then one dirty miss.
    pulse_reset();
    drive_set(vecs[2]);
    wb_rdy = 1'b1; fill_rdy = 1'b1; fill_data_v = 1'b1; miss_v = 1'b1;
    g_lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (miss_done) begin g_lat = n; break; end
    end
    chk("t6_first_lat", 32'(g_lat), 32'd4);
    chk("t6_commit_busy", 32'(miss_rdy), 32'd0);
    @(negedge clk);
    chk("t6_idle_after_commit", 32'(miss_rdy), 32'd1);
    @(negedge clk);
    chk("t6_second_accepted", 32'(miss_rdy), 32'd0);
    miss_v = 1'b0;
    g_lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (miss_done) begin g_lat = n; break; end
    end
    chk("t6_second_lat", 32'(g_lat), 32'd3);
    chk("t6_second_way", 32'(way_we), 32'b0001);
    do_miss(vecs[1], g_we, g_touch, g_wb, g_wba, g_wbw, g_fa, g_lat, g_stray);
    chk("t6_dirty_wb", 32'(g_wb), 32'd1);
    chk("t6_dirty_lat", 32'(g_lat), 32'd5);
`ifdef VICTIM_CTRL_PERF_EN
    @(negedge clk);
    chk("perf_miss_cnt", 32'(perf_miss_cnt), 32'd3);
    chk("perf_wb_cnt", 32'(perf_wb_cnt), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
